// File: rtl/usb_pkg.sv
// Shared USB constants, FSM state type and CRC16 byte step.
package usb_pkg;

    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_NAK,
        ST_WAIT
    } usb_in_state_t;

    // Reflected CRC: data bits enter LSB first.
    function automatic logic [15:0] crc16_byte(
        input logic [15:0] crc,
        input logic [7:0]  d
    );
        logic [15:0] c;
        c = crc ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 register with synchronous init and enable.
module usb_crc16
    import usb_pkg::*;
(
    input  logic        r_clk,
    input  logic        rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge r_clk or negedge rst) begin
        if (!rst) begin
            r_crc <= CRC16_INIT;
        end else if (i_init) begin
            r_crc <= CRC16_INIT;
        end else if (i_en) begin
            r_crc <= crc16_byte(r_crc, i_data);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/usb_in_packetizer.sv
// USB IN-endpoint packetizer with ACK-gated replay buffer.
// Define USB_IN_ZLP_EN to send a zero-length packet after a full one.
module usb_in_packetizer
    import usb_pkg::*;
#(
    parameter int MAX_PKT = 64
) (
    input  logic       r_clk,
    input  logic       rst,
    input  logic       in_req,
    input  logic       ack_rx,
    input  logic       ack_timeout,
    input  logic [7:0] q_data,
    input  logic       q_empty,
    output logic       q_rd,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    output logic       toggle,
    output logic       busy
);

    localparam int AW = $clog2(MAX_PKT);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PKT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    usb_in_state_t r_state, w_state_nx;

    logic [7:0]    r_buf [MAX_PKT];
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [CW-1:0] r_len, w_len_nx;
    logic [CW-1:0] r_idx, w_idx_nx;
    logic          r_locked, w_locked_nx;
    logic          r_toggle, w_toggle_nx;
    logic          w_hs, w_fill, w_zlp_ok;
    logic          w_crc_init, w_crc_en;
    logic [15:0]   w_crc;
    logic [7:0]    w_byte;

`ifdef USB_IN_ZLP_EN
    logic r_last_full, w_last_full_nx;
    assign w_zlp_ok = r_last_full;
`else
    assign w_zlp_ok = 1'b0;
`endif

    assign w_byte = r_buf[r_idx[AW-1:0]];
    assign w_hs   = tx_valid & tx_ready;
    assign w_fill = rst & (r_state == ST_IDLE) & ~r_locked & ~q_empty
                  & (r_cnt < CNT_MAX) & ~in_req;
    assign q_rd   = w_fill;
    assign toggle = r_toggle;
    assign busy   = (r_state != ST_IDLE);

    usb_crc16 u_crc (
        .r_clk  (r_clk),
        .rst    (rst),
        .i_init (w_crc_init),
        .i_en   (w_crc_en),
        .i_data (w_byte),
        .o_crc  (w_crc)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_len_nx    = r_len;
        w_idx_nx    = r_idx;
        w_locked_nx = r_locked;
        w_toggle_nx = r_toggle;
`ifdef USB_IN_ZLP_EN
        w_last_full_nx = r_last_full;
`endif
        w_crc_init  = 1'b0;
        w_crc_en    = 1'b0;
        tx_valid    = 1'b0;
        tx_last     = 1'b0;
        tx_data     = 8'h00;

        if (w_fill) begin
            w_cnt_nx = r_cnt + CNT_ONE;
        end

        unique case (r_state)
            ST_IDLE: begin
                if (in_req) begin
                    if (r_cnt != '0 || w_zlp_ok) begin
                        w_locked_nx = 1'b1;
                        w_len_nx    = r_cnt;
                        w_idx_nx    = '0;
                        w_crc_init  = 1'b1;
                        w_state_nx  = ST_PID;
                    end else begin
                        w_state_nx  = ST_NAK;
                    end
                end
            end
            ST_PID: begin
                tx_valid = 1'b1;
                tx_data  = r_toggle ? PID_DATA1 : PID_DATA0;
                if (w_hs) begin
                    w_state_nx = (r_len == '0) ? ST_CRC_LO : ST_DATA;
                end
            end
            ST_DATA: begin
                tx_valid = 1'b1;
                tx_data  = w_byte;
                if (w_hs) begin
                    w_crc_en = 1'b1;
                    if (r_idx == r_len - CNT_ONE) begin
                        w_state_nx = ST_CRC_LO;
                    end else begin
                        w_idx_nx = r_idx + CNT_ONE;
                    end
                end
            end
            ST_CRC_LO: begin
                tx_valid = 1'b1;
                tx_data  = ~w_crc[7:0];
                if (w_hs) begin
                    w_state_nx = ST_CRC_HI;
                end
            end
            ST_CRC_HI: begin
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                tx_data  = ~w_crc[15:8];
                if (w_hs) begin
                    w_state_nx = ST_WAIT;
                end
            end
            ST_NAK: begin
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                tx_data  = PID_NAK;
                if (w_hs) begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // ACK beats a simultaneous timeout; timeout keeps the replay copy.
                if (ack_rx) begin
                    w_toggle_nx = ~r_toggle;
                    w_cnt_nx    = '0;
                    w_locked_nx = 1'b0;
`ifdef USB_IN_ZLP_EN
                    w_last_full_nx = (r_len == CNT_MAX);
`endif
                    w_state_nx  = ST_IDLE;
                end else if (ack_timeout) begin
                    w_state_nx  = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge r_clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_locked <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_len    <= w_len_nx;
            r_idx    <= w_idx_nx;
            r_locked <= w_locked_nx;
            r_toggle <= w_toggle_nx;
        end
    end

`ifdef USB_IN_ZLP_EN
    always_ff @(posedge r_clk or negedge rst) begin
        if (!rst) begin
            r_last_full <= 1'b0;
        end else begin
            r_last_full <= w_last_full_nx;
        end
    end
`endif

    always_ff @(posedge r_clk) begin
        if (w_fill) begin
            r_buf[r_cnt[AW-1:0]] <= q_data;
        end
    end

endmodule

// File: tb/tb_usb_in_packetizer.sv
// Randomized bench for usb_in_packetizer against a packet-level model.
module tb_usb_in_packetizer;

    localparam int MAX = 64;
`ifdef USB_IN_ZLP_EN
    localparam bit ZLP = 1'b1;
`else
    localparam bit ZLP = 1'b0;
`endif

    logic       r_clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_req = 1'b0;
    logic       ack_rx = 1'b0;
    logic       ack_timeout = 1'b0;
    logic [7:0] q_data = 8'h00;
    logic       q_empty = 1'b1;
    logic       tx_ready = 1'b0;
    logic       q_rd, tx_valid, tx_last, toggle, busy;
    logic [7:0] tx_data;

    usb_in_packetizer #(.MAX_PKT(MAX)) dut (
        .r_clk       (r_clk),
        .rst         (rst),
        .in_req      (in_req),
        .ack_rx      (ack_rx),
        .ack_timeout (ack_timeout),
        .q_data      (q_data),
        .q_empty     (q_empty),
        .q_rd        (q_rd),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_last     (tx_last),
        .toggle      (toggle),
        .busy        (busy)
    );

    always #5 r_clk = ~r_clk;

    int total = 0;
    int bad = 0;
    int rdy_pct = 100;

    byte unsigned src[$];
    byte unsigned log_q[$];
    logic         s_qrd = 1'b0;

    // Model: phase 0 idle, 1 sending, 2 awaiting handshake.
    byte unsigned m_buf[$];
    byte unsigned m_pkt[$];
    int           m_phase = 0;
    int           m_p = 0;
    int           m_len = 0;
    bit           m_nak = 0;
    bit           m_locked = 0;
    bit           m_toggle = 0;
    bit           m_last_full = 0;

    function automatic logic [15:0] ref_crc(input byte unsigned d[$]);
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'hFFFF;
        foreach (d[i]) begin
            b = d[i];
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[k];
                c = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge r_clk) begin
        int  ph0;
        bit  exp_rd;
        logic [15:0] c;
        if (!rst) begin
            m_buf.delete();
            m_phase = 0;
            m_locked = 0;
            m_toggle = 0;
            m_last_full = 0;
            s_qrd = q_rd;
        end else begin
            ph0 = m_phase;
            exp_rd = (ph0 == 0) && !m_locked && !q_empty
                  && (m_buf.size() < MAX) && !in_req;
            chk("q_rd", q_rd, exp_rd);
            s_qrd = q_rd;
            chk("busy", busy, ph0 != 0);
            chk("toggle", toggle, m_toggle);
            if (ph0 == 1) begin
                chk("tx_valid", tx_valid, 1);
                chk("tx_data", tx_data, m_pkt[m_p]);
                chk("tx_last", tx_last, m_p == m_pkt.size() - 1);
                if (tx_valid && tx_ready) begin
                    log_q.push_back(tx_data);
                    m_p++;
                    if (m_p == m_pkt.size()) m_phase = m_nak ? 0 : 2;
                end
            end else begin
                chk("tx_valid_idle", tx_valid, 0);
                chk("tx_last_idle", tx_last, 0);
            end
            if (ph0 == 0 && in_req) begin
                m_pkt.delete();
                m_p = 0;
                m_phase = 1;
                if (m_buf.size() > 0 || (ZLP && m_last_full)) begin
                    m_pkt.push_back(m_toggle ? 8'h4B : 8'hC3);
                    foreach (m_buf[i]) m_pkt.push_back(m_buf[i]);
                    c = ref_crc(m_buf);
                    m_pkt.push_back(c[7:0]);
                    m_pkt.push_back(c[15:8]);
                    m_len = m_buf.size();
                    m_locked = 1;
                    m_nak = 0;
                end else begin
                    m_pkt.push_back(8'h5A);
                    m_nak = 1;
                end
            end else if (ph0 == 2) begin
                if (ack_rx) begin
                    m_toggle = ~m_toggle;
                    m_last_full = (m_len == MAX);
                    m_buf.delete();
                    m_locked = 0;
                    m_phase = 0;
                end else if (ack_timeout) begin
                    m_phase = 0;
                end
            end
            if (exp_rd) m_buf.push_back(q_data);
        end
    end

    task automatic step(input bit rq, input bit ak, input bit to);
        @(posedge r_clk);
        #1;
        if (s_qrd && src.size() > 0) void'(src.pop_front());
        q_empty = (src.size() == 0);
        q_data = q_empty ? 8'h00 : src[0];
        in_req = rq;
        ack_rx = ak;
        ack_timeout = to;
        tx_ready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) src.push_back(8'($urandom_range(255)));
    endtask

    task automatic run_pkt();
        log_q.delete();
        step(1, 0, 0);
        for (int i = 0; i < 600; i++) begin
            step(0, 0, 0);
            if (m_phase != 1) break;
        end
        chk("pkt_done", m_phase != 1, 1);
    endtask

    byte unsigned first[$];
    byte unsigned tmp[$];
    string        s9;

    initial begin
        // Model anchor: CRC-16/USB check value of "123456789".
        s9 = "123456789";
        tmp.delete();
        for (int i = 0; i < 9; i++) tmp.push_back(s9[i]);
        chk("crc_anchor", ref_crc(tmp), 16'hB4C8);
        tmp.delete();
        chk("crc_empty", ref_crc(tmp), 16'h0000);

        idle(3);
        @(negedge r_clk);
        chk("rst_q_rd", q_rd, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_toggle", toggle, 0);
        @(posedge r_clk);
        #1 rst = 1'b1;

        rdy_pct = 100;
        for (int i = 1; i <= 4; i++) src.push_back(8'(i));
        idle(10);
        run_pkt();
        chk("t1_len", log_q.size(), 7);
        for (int i = 0; i < 5; i++) begin
            tmp.push_back(8'(i));
        end
        chk("t1_pid", log_q[0], 8'hC3);
        for (int i = 1; i <= 4; i++) chk("t1_byte", log_q[i], i);
        tmp.delete();
        for (int i = 1; i <= 4; i++) tmp.push_back(8'(i));
        chk("t1_crc", {log_q[6], log_q[5]}, ref_crc(tmp));
        step(0, 1, 0);
        idle(1);
        chk("t1_toggle", toggle, 1);

        idle(3);
        run_pkt();
        chk("nak_len", log_q.size(), 1);
        chk("nak_byte", log_q[0], 8'h5A);
        chk("nak_toggle", toggle, 1);

        push_rand(MAX + 3);
        idle(MAX + 10);
        run_pkt();
        chk("full_len", log_q.size(), MAX + 3);
        chk("full_pid", log_q[0], 8'h4B);
        step(0, 1, 0);
        idle(10);
        run_pkt();
        chk("rest_len", log_q.size(), 6);
        chk("rest_pid", log_q[0], 8'hC3);
        step(0, 1, 0);

        push_rand(5);
        idle(10);
        run_pkt();
        first = log_q;
        step(0, 0, 1);
        push_rand(4);
        idle(10);
        run_pkt();
        chk("retry_len", log_q.size(), first.size());
        for (int i = 0; i < first.size(); i++) chk("retry_byte", log_q[i], first[i]);
        step(0, 1, 0);
        idle(10);
        run_pkt();
        chk("after_retry_len", log_q.size(), 7);
        step(0, 1, 1);

        rdy_pct = 50;
        push_rand(20);
        idle(30);
        run_pkt();
        chk("rand_len", log_q.size(), 23);
        step(0, 1, 0);
        for (int it = 0; it < 8; it++) begin
            push_rand($urandom_range(0, 70));
            idle(80);
            run_pkt();
            if (m_phase == 2) begin
                case ($urandom_range(2))
                    0: step(0, 1, 0);
                    1: step(0, 0, 1);
                    default: step(0, 1, 1);
                endcase
            end
        end

        rdy_pct = 100;
        for (int t = 0; t < 6; t++) begin
            if (src.size() == 0 && m_buf.size() == 0 && !m_locked) break;
            idle(80);
            run_pkt();
            if (m_phase == 2) step(0, 1, 0);
        end
        chk("drained", src.size() + m_buf.size(), 0);
        push_rand(MAX);
        idle(MAX + 10);
        run_pkt();
        chk("zlp_full_len", log_q.size(), MAX + 3);
        step(0, 1, 0);
        idle(3);
        run_pkt();
        chk("zlp_len", log_q.size(), ZLP ? 3 : 1);
        chk("zlp_first", log_q[0], ZLP ? (m_toggle ? 8'h4B : 8'hC3) : 8'h5A);
        if (m_phase == 2) step(0, 1, 0);

        push_rand(10);
        idle(15);
        step(1, 0, 0);
        idle(3);
        rst = 1'b0;
        @(negedge r_clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", tx_valid, 0);
        chk("mid_rst_toggle", toggle, 0);
        @(posedge r_clk);
        #1 rst = 1'b1;
        push_rand(3);
        idle(20);
        run_pkt();
        chk("post_rst_len", log_q.size(), 6);
        step(0, 1, 0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_in_packetizer.md
Name: usb_in_packetizer

Overview:
- Drains the byte queue from its read side and builds USB IN-endpoint DATA0/DATA1 packets (PID, payload, CRC16) for the byte-level transmitter.
- Holds each packet in a local replay buffer until ACK, so a timed-out packet is resent unchanged with the same PID.
- Answers NAK when no data is buffered.
- Sits between the endpoint queue and the PHY serializer, all in the r_clk domain.

Parameters:
- MAX_PKT, 64, maximum payload bytes per packet (power of two, 8..64).

Ports:
- r_clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_req  in  1  one-cycle pulse: IN token addressed to this endpoint
- ack_rx  in  1  one-cycle pulse: host ACK received
- ack_timeout  in  1  one-cycle pulse: no handshake within turnaround window
- q_data  in  8  queue head byte (combinational, valid while ~q_empty)
- q_empty  in  1  queue empty
- q_rd  out  1  pop queue head this cycle
- tx_data  out  8  byte to serializer
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  serializer accepts byte when tx_valid&tx_ready
- tx_last  out  1  marks last byte of packet
- toggle  out  1  PID of next/pending DATA packet: 0=DATA0, 1=DATA1
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst low): state IDLE, buf_cnt=0, locked=0, toggle=0, last_full=0; q_rd=0, tx_valid=0, tx_last=0, tx_data=0, busy=0.
- Fill:
  - q_rd = (state==IDLE) & ~locked & ~q_empty & (buf_cnt<MAX_PKT) & ~in_req.
  - On q_rd, q_data is written to buf[buf_cnt] and buf_cnt increments at the same edge.
  - buf_cnt width is $clog2(MAX_PKT)+1, so count MAX_PKT is representable.
- IDLE + in_req:
  - buf_cnt>0 -> set locked=1, snapshot len=buf_cnt, go SEND_PID.
  - buf_cnt==0 -> SEND_NAK.
  - in_req in any other state is ignored.
- SEND_PID: tx_data = toggle ? 8'h4B : 8'hC3, tx_valid=1. On handshake go SEND_DATA, or SEND_CRC_LO if len==0.
- SEND_DATA: tx_data=buf[idx]. Each handshake updates CRC and increments idx; after byte len-1 go SEND_CRC_LO.
- CRC16:
  - Polynomial x^16+x^15+x^2+1, bit-reflected (LSB-first), init 16'hFFFF.
  - Transmitted value is ~crc: low byte first, then high byte.
  - SEND_CRC_HI drives tx_last=1.
  - CRC register reinitialised on entry to SEND_PID.
- SEND_NAK: tx_data=8'h5A, tx_valid=1, tx_last=1. On handshake go IDLE. toggle unchanged.
- WAIT_ACK: entered after the CRC_HI handshake.
  - ack_rx -> toggle flips, last_full=(len==MAX_PKT), buf_cnt=0, locked=0, go IDLE.
  - ack_timeout -> go IDLE with locked=1, buffer and toggle unchanged. The next in_req resends an identical packet.
  - ack_rx and ack_timeout in the same cycle: ack_rx wins.
- tx_valid holds and tx_data stays stable until tx_ready. There is no combinational path from tx_ready to tx_valid.
- Latency: in_req at edge N -> tx_valid=1 with PID from cycle N+1.
- Boundaries:
  - buf_cnt==MAX_PKT stops fill even if the queue is non-empty.
  - Queue empty mid-fill: the packet is sent with the partial count.
  - Fill never occurs while locked or outside IDLE.
  - Reset mid-packet aborts immediately. Buffered bytes are lost and the queue is not rewound.

Optional Feature:
- Macro: USB_IN_ZLP_EN.
- Defined: in IDLE, in_req with buf_cnt==0 and last_full==1 sends a zero-length DATA packet: PID, CRC 8'h00, 8'h00. It is acked/retried like any DATA packet. last_full clears on its ACK.
- Not defined: buf_cnt==0 always answers NAK, and last_full logic is absent.

Decomposition:
- Shared package usb_pkg:
  - PID constants PID_DATA0=8'hC3, PID_DATA1=8'h4B, PID_NAK=8'h5A.
  - CRC16_POLY_REFL=16'hA001, CRC16_INIT=16'hFFFF.
  - State enum typedef.
- Sub-module usb_crc16: byte-wide combinational next-CRC function plus register, with init/enable inputs. The same sub-module is reused by the OUT receiver.

Test Plan:
- Push 4 bytes 01 02 03 04 into queue, idle 10 cycles, in_req, tx_ready=1 -> C3 01 02 03 04 CRClo CRChi. tx_last only on the final byte. CRC matches the reference model.
- Empty queue, in_req -> single byte 5A with tx_last=1. toggle stays 0. q_rd never asserted.
- Queue holds MAX_PKT+3 bytes, in_req, ack_rx -> 64-byte DATA0 packet. toggle=1. The remaining 3 bytes are refilled. The next in_req sends DATA1 with 3 bytes.
- Packet sent, ack_timeout, new bytes pushed meanwhile, in_req -> byte-identical DATA0 resend. No q_rd while locked.
- tx_ready toggled randomly 50% during a packet -> identical byte sequence. tx_data stable while tx_valid&~tx_ready.
- USB_IN_ZLP_EN: exactly MAX_PKT bytes, ack, in_req -> C3 00 00 (ZLP, toggle 1->DATA1 PID 4B if toggle=1). Without the macro -> 5A.
